// File: rtl/regfile_mp_if.sv
// regfile_mp port bundle: read ports, write port, clear request and status.
// master drives requests (core side), slave is the register file.
interface regfile_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int AW    = $clog2(NREGS)
);
   logic                clear_req;
   logic                ready;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                wr_drop;

   modport master (
      output clear_req, rd_addr, wr_en, wr_addr, wr_data,
      input  ready, rd_data, wr_drop
   );

   modport slave (
      input  clear_req, rd_addr, wr_en, wr_addr, wr_data,
      output ready, rd_data, wr_drop
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file, x0 reads zero, array cleared by an NREGS-cycle sweep; reads are 0-latency.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding on every read port.
module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
) (
   input  logic        clk,
   input  logic        reset,
   regfile_mp_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       ptr_q, ptr_d;
   logic                drop_q, drop_d;
   logic                ready_c;
   logic                wr_valid;
   logic                mem_we;
   logic [AW-1:0]       mem_waddr;
   logic [XLEN-1:0]     mem_wdata;
   logic [NRD*XLEN-1:0] rd_data_c;
   logic [XLEN-1:0]     mem [NREGS];

   // Writes to x0 are ignored silently, so they never count as valid or dropped.
   assign wr_valid = bus.wr_en && (bus.wr_addr != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      drop_d    = 1'b0;
      ready_c   = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = '0;
      case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            drop_d = wr_valid;
            if (bus.clear_req) begin
               ptr_d = '0;
            end else if (ptr_q == AW'(NREGS - 1)) begin
               state_d = RUN;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
         end
         RUN: begin
            ready_c = 1'b1;
            if (bus.clear_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
               drop_d  = wr_valid;
            end else if (wr_valid) begin
               mem_we    = 1'b1;
               mem_waddr = bus.wr_addr;
               mem_wdata = bus.wr_data;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   // Storage has no reset so it can map onto RAM; the sweep does the clearing.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      rd_data_c = '0;
      for (int p = 0; p < NRD; p++) begin
         if (ready_c && (bus.rd_addr[p*AW +: AW] != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && !bus.clear_req && (bus.rd_addr[p*AW +: AW] == bus.wr_addr)) begin
               rd_data_c[p*XLEN +: XLEN] = bus.wr_data;
            end else begin
               rd_data_c[p*XLEN +: XLEN] = mem[bus.rd_addr[p*AW +: AW]];
            end
`else
            rd_data_c[p*XLEN +: XLEN] = mem[bus.rd_addr[p*AW +: AW]];
`endif
         end
      end
   end

   assign bus.ready   = ready_c;
   assign bus.rd_data = rd_data_c;
   assign bus.wr_drop = drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32x2 instance plus a 64-bit, 16-entry, 3-port instance.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
   regfile_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) ifb ();

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   task automatic idle_all();
      ifa.clear_req = 1'b0;
      ifa.rd_addr   = '0;
      ifa.wr_en     = 1'b0;
      ifa.wr_addr   = '0;
      ifa.wr_data   = '0;
      ifb.clear_req = 1'b0;
      ifb.rd_addr   = '0;
      ifb.wr_en     = 1'b0;
      ifb.wr_addr   = '0;
      ifb.wr_data   = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts the 32 sweep edges; optionally injects a write at sweep edge 3 to check wr_drop.
   task automatic wait_sweep_a(input string name, input bit inject);
      int bad;
      bad = 0;
      for (int i = 1; i <= 31; i++) begin
         step();
         if (ifa.ready !== 1'b0) bad++;
         if (inject && i == 1) begin
            checks++;
            if (ifa.wr_drop !== 1'b0) begin
               failures++;
               $display("FAIL %s_drop_one_cycle actual=%0b expected=0", name, ifa.wr_drop);
            end
         end
         if (inject && i == 3) begin
            ifa.wr_en   = 1'b1;
            ifa.wr_addr = 5'd3;
            ifa.wr_data = 32'h0BAD_F00D;
         end
         if (inject && i == 4) begin
            ifa.wr_en = 1'b0;
            checks++;
            if (ifa.wr_drop !== 1'b1) begin
               failures++;
               $display("FAIL %s_drop_in_clear actual=%0b expected=1", name, ifa.wr_drop);
            end
         end
         if (inject && i == 5) begin
            checks++;
            if (ifa.wr_drop !== 1'b0) begin
               failures++;
               $display("FAIL %s_drop_fall actual=%0b expected=0", name, ifa.wr_drop);
            end
         end
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL %s_ready_low actual_high_cycles=%0d expected=0", name, bad);
      end
      step();
      checks++;
      if (ifa.ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_ready_rise actual=%0b expected=1", name, ifa.ready);
      end
   endtask

   task automatic test_reset();
      idle_all();
      reset = 1'b1;
      #1;
      checks++;
      if (ifa.ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready actual=%0b expected=0", ifa.ready);
      end
      repeat (2) step();
      checks++;
      if (ifa.wr_drop !== 1'b0) begin
         failures++;
         $display("FAIL reset_wr_drop actual=%0b expected=0", ifa.wr_drop);
      end
      reset = 1'b0;
      wait_sweep_a("reset", 1'b0);
   endtask

   task automatic test_clear_reads();
      for (int a = 1; a < 32; a++) begin
         ifa.rd_addr = {5'(a), 5'(a)};
         #1;
         checks++;
         if (ifa.rd_data[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL clear_read_p0 x%0d actual=%h expected=0", a, ifa.rd_data[31:0]);
         end
         checks++;
         if (ifa.rd_data[63:32] !== 32'h0) begin
            failures++;
            $display("FAIL clear_read_p1 x%0d actual=%h expected=0", a, ifa.rd_data[63:32]);
         end
      end
   endtask

   task automatic test_write_fwd();
      logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hDEAD_BEEF;
`else
      exp_same = 32'h0;
`endif
      step();
      ifa.wr_en   = 1'b1;
      ifa.wr_addr = 5'd5;
      ifa.wr_data = 32'hDEAD_BEEF;
      ifa.rd_addr = {5'd5, 5'd5};
      #1;
      checks++;
      if (ifa.rd_data[31:0] !== exp_same) begin
         failures++;
         $display("FAIL fwd_same_p0 actual=%h expected=%h", ifa.rd_data[31:0], exp_same);
      end
      checks++;
      if (ifa.rd_data[63:32] !== exp_same) begin
         failures++;
         $display("FAIL fwd_same_p1 actual=%h expected=%h", ifa.rd_data[63:32], exp_same);
      end
      step();
      ifa.wr_en = 1'b0;
      #1;
      checks++;
      if (ifa.rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
         failures++;
         $display("FAIL write_readback actual=%h expected=deadbeefdeadbeef", ifa.rd_data);
      end
      checks++;
      if (ifa.wr_drop !== 1'b0) begin
         failures++;
         $display("FAIL write_no_drop actual=%0b expected=0", ifa.wr_drop);
      end
   endtask

   task automatic test_write_x0();
      step();
      ifa.wr_en   = 1'b1;
      ifa.wr_addr = 5'd0;
      ifa.wr_data = 32'hFFFF_FFFF;
      ifa.rd_addr = {5'd5, 5'd0};
      #1;
      checks++;
      if (ifa.rd_data[31:0] !== 32'h0) begin
         failures++;
         $display("FAIL x0_same actual=%h expected=0", ifa.rd_data[31:0]);
      end
      step();
      ifa.wr_en = 1'b0;
      #1;
      checks++;
      if (ifa.wr_drop !== 1'b0) begin
         failures++;
         $display("FAIL x0_drop actual=%0b expected=0", ifa.wr_drop);
      end
      checks++;
      if (ifa.rd_data !== {32'hDEAD_BEEF, 32'h0}) begin
         failures++;
         $display("FAIL x0_after actual=%h expected=deadbeef00000000", ifa.rd_data);
      end
   endtask

   task automatic test_clear_req();
      step();
      ifa.wr_en   = 1'b1;
      ifa.wr_addr = 5'd7;
      ifa.wr_data = 32'h1234_5678;
      step();
      ifa.wr_addr   = 5'd9;
      ifa.wr_data   = 32'hA5A5_A5A5;
      ifa.clear_req = 1'b1;
      ifa.rd_addr   = {5'd9, 5'd7};
      #1;
      checks++;
      if (ifa.rd_data !== {32'h0, 32'h1234_5678}) begin
         failures++;
         $display("FAIL clrreq_same actual=%h expected=0000000012345678", ifa.rd_data);
      end
      step();
      ifa.clear_req = 1'b0;
      ifa.wr_en     = 1'b0;
      checks++;
      if (ifa.wr_drop !== 1'b1) begin
         failures++;
         $display("FAIL clrreq_drop actual=%0b expected=1", ifa.wr_drop);
      end
      checks++;
      if (ifa.ready !== 1'b0) begin
         failures++;
         $display("FAIL clrreq_ready_fall actual=%0b expected=0", ifa.ready);
      end
      wait_sweep_a("clrreq", 1'b1);
      ifa.rd_addr = {5'd9, 5'd7};
      #1;
      checks++;
      if (ifa.rd_data !== 64'h0) begin
         failures++;
         $display("FAIL clrreq_x7_x9 actual=%h expected=0", ifa.rd_data);
      end
      ifa.rd_addr = {5'd3, 5'd3};
      #1;
      checks++;
      if (ifa.rd_data !== 64'h0) begin
         failures++;
         $display("FAIL clrreq_x3 actual=%h expected=0", ifa.rd_data);
      end
   endtask

   task automatic test_reset_mid();
      step();
      ifa.wr_en   = 1'b1;
      ifa.wr_addr = 5'd4;
      ifa.wr_data = 32'hCAFE_0004;
      step();
      ifa.wr_en = 1'b0;
      reset     = 1'b1;
      step();
      reset = 1'b0;
      repeat (10) step();
      reset = 1'b1;
      #1;
      checks++;
      if (ifa.ready !== 1'b0) begin
         failures++;
         $display("FAIL midreset_ready actual=%0b expected=0", ifa.ready);
      end
      step();
      reset = 1'b0;
      wait_sweep_a("midreset", 1'b0);
      ifa.rd_addr = {5'd4, 5'd4};
      #1;
      checks++;
      if (ifa.rd_data !== 64'h0) begin
         failures++;
         $display("FAIL midreset_x4 actual=%h expected=0", ifa.rd_data);
      end
   endtask

   task automatic test_cfg3();
      int bad;
      bad   = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (ifb.ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL cfg3_ready_low actual_high_cycles=%0d expected=0", bad);
      end
      step();
      checks++;
      if (ifb.ready !== 1'b1) begin
         failures++;
         $display("FAIL cfg3_ready_rise actual=%0b expected=1", ifb.ready);
      end
      ifb.wr_en   = 1'b1;
      ifb.wr_addr = 4'd15;
      ifb.wr_data = 64'h0123_4567_89AB_CDEF;
      step();
      ifb.wr_en   = 1'b0;
      ifb.rd_addr = {4'd15, 4'd0, 4'd15};
      #1;
      checks++;
      if (ifb.rd_data[63:0] !== 64'h0123_4567_89AB_CDEF) begin
         failures++;
         $display("FAIL cfg3_p0 actual=%h expected=0123456789abcdef", ifb.rd_data[63:0]);
      end
      checks++;
      if (ifb.rd_data[127:64] !== 64'h0) begin
         failures++;
         $display("FAIL cfg3_p1 actual=%h expected=0", ifb.rd_data[127:64]);
      end
      checks++;
      if (ifb.rd_data[191:128] !== 64'h0123_4567_89AB_CDEF) begin
         failures++;
         $display("FAIL cfg3_p2 actual=%h expected=0123456789abcdef", ifb.rd_data[191:128]);
      end
   endtask

   initial begin
      test_reset();
      test_clear_reads();
      test_write_fwd();
      test_write_x0();
      test_clear_req();
      test_reset_mid();
      test_cfg3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file. It is the successor to the fixed 32×32 two-read-port register file. Entry 0 is hardwired to zero. Width, depth and read-port count are configurable. The array is cleared by a sequential sweep FSM rather than a parallel reset, so it can map onto RAM, and a `ready` output gates writes. Optional same-cycle write-to-read forwarding serves the decode/operand-fetch stage of the core pipeline.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREGS), address width (derived, not overridden)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- clear_req  in  1  request a full array clear (single-cycle pulse or level)
- ready  out  1  high when array is valid and writes are accepted
- rd_addr  in  NRD*AW  read addresses; port p at bits [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port p at bits [p*XLEN +: XLEN]
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- wr_drop  out  1  registered one-cycle pulse: previous cycle's write was discarded

## Operation
- FSM states: CLEAR, RUN.
  - Reset value: state=CLEAR, sweep pointer ptr=0, ready=0, wr_drop=0.
  - Array contents are not touched by reset itself.
- CLEAR:
  - Each cycle writes 0 to entry ptr, then ptr increments.
  - When ptr==NREGS-1 is written, the next state is RUN.
  - ready=0 throughout.
- RUN: ready=1. A write is committed on the edge when wr_en=1, wr_addr≠0 and clear_req=0.
- clear_req:
  - In RUN: next state is CLEAR, ptr=0. clear_req has priority over a same-cycle write, which is discarded.
  - In CLEAR: ptr restarts at 0.
- Discarded writes: a write with wr_en=1 and wr_addr≠0 is discarded if state=CLEAR or clear_req=1. wr_drop=1 on the following cycle.
- Writes to address 0 are always ignored silently and never raise wr_drop.
- Reads:
  - Combinational and independent per port.
  - rd_addr=0 returns 0.
  - Any read while ready=0 returns 0.
- Multiple ports may read the same address concurrently. All of them return identical data.
- Width: wr_data is stored unmodified. No sign or zero extension.

## Timing
- Read latency: 0 cycles (combinational from rd_addr).
- Write latency: data is visible on rd_data from the cycle after the committing edge.
  - With forwarding enabled (see Configuration), it is also visible in the same cycle.
- Clear duration: exactly NREGS rising edges in CLEAR.
  - After reset deassertion, ready rises after edge NREGS. The default is 32 cycles.
- clear_req in RUN: ready falls on the next edge and rises NREGS edges after that.
- Reset asserted mid-sweep: the FSM returns asynchronously to CLEAR with ptr=0 and the full sweep repeats.
- wr_drop is high for exactly one cycle per discarded write. Back-to-back discarded writes hold it high continuously.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding.
  - If ready=1, wr_en=1, wr_addr≠0, clear_req=0 and rd_addr[p]==wr_addr, then rd_data[p]=wr_data in the same cycle.
  - This applies to every port independently.
- Undefined: no forwarding. rd_data returns the stored (old) value until after the write edge.
- Both builds must pass the test plan. The same-cycle expectations differ as stated in scenario 2.

## Test plan
- Reset → clear → read: assert reset, release it and wait 32 edges. Expect ready=0 before edge 32 and ready=1 after it. Read x1..x31 on both ports; all return 0.
- Write and read back, with and without forwarding:
  - Write x5=0xDEADBEEF while reading x5 on port 0 in the same cycle.
  - With REGFILE_BYPASS_EN, the same cycle returns 0xDEADBEEF. Without it, the same cycle returns 0.
  - From the next cycle, both builds return 0xDEADBEEF.
- Write to x0: write x0=0xFFFFFFFF. Reading x0 returns 0 and wr_drop stays 0.
- clear_req with a same-cycle write:
  - After writing x7=0x12345678, pulse clear_req together with a write of x9=0xA5A5A5A5.
  - Expect wr_drop=1 on the next cycle and ready=0 for 32 cycles.
  - Afterwards, x7 and x9 both read 0.
- Reset mid-sweep: assert reset at sweep cycle 10. After release, ready stays 0 for a full 32 edges.
- Configuration NRD=3, XLEN=64, NREGS=16:
  - Write x15=0x0123456789ABCDEF.
  - Ports 0, 1 and 2 reading x15, x0 and x15 return the value, 0 and the value respectively.
  - Clear takes 16 cycles.
